// File: rtl/instruction_fetch_pkg.sv
// Shared CPU package for the fetch stage: FSM state encoding, instruction size
// and the PC alignment helper.
package instruction_fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2,
    FULL    = 2'd3
  } fetch_state_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: one outstanding memory read, a single-entry
// instruction register towards decode, and redirect handling from execute.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next;
  logic [31:0]  hold_addr, hold_next;
  logic         capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A redirect always wins over the sequential pc+4 path; in FETCH without an
  // ack the in-flight address is parked in hold_addr so the bus stays stable.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    hold_next  = hold_addr;
    capture    = 1'b0;
    imem_req   = 1'b0;
    imem_addr  = pc;
    case (state)
      IDLE: begin
        state_next = FETCH;
        if (redirect) begin
          pc_next = align_pc(redirect_pc);
        end
      end
      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_next = align_pc(redirect_pc);
          if (!imem_ack) begin
            hold_next  = pc;
            state_next = DISCARD;
          end
        end else if (imem_ack) begin
          capture    = 1'b1;
          pc_next    = pc + 32'(INSTR_BYTES);
          state_next = FULL;
        end
      end
      DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = hold_addr;
        if (redirect) begin
          pc_next = align_pc(redirect_pc);
        end
        if (imem_ack) begin
          state_next = FETCH;
        end
      end
      FULL: begin
        if (redirect) begin
          pc_next    = align_pc(redirect_pc);
          state_next = FETCH;
        end else if (instr_ready) begin
          state_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      hold_addr <= 32'h0;
    end else begin
      pc        <= pc_next;
      hold_addr <= hold_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= 32'h0;
      instr_pc <= 32'h0;
    end else if (capture) begin
      instr    <= imem_rdata;
      instr_pc <= pc;
    end
  end

  assign instr_valid = (state == FULL);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, a reset
// corner sequence, and randomized traffic against a stream-level model.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int tests;
  int failures;

  typedef struct packed {
    logic        ack;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expInstr;
    logic [31:0] expIpc;
  } vec_t;

  vec_t vecs [19];

  instruction_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic ack, input logic [31:0] rdata,
                              input logic redir, input logic [31:0] rpc,
                              input logic ready, input logic expReq,
                              input logic [31:0] expAddr, input logic expValid,
                              input logic [31:0] expInstr, input logic [31:0] expIpc);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.redir = redir; v.rpc = rpc; v.ready = ready;
    v.expReq = expReq; v.expAddr = expAddr; v.expValid = expValid;
    v.expInstr = expInstr; v.expIpc = expIpc;
    return v;
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    imem_ack    = v.ack;
    imem_rdata  = v.rdata;
    redirect    = v.redir;
    redirect_pc = v.rpc;
    instr_ready = v.ready;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    check($sformatf("vec%0d imem_req", idx), 32'(imem_req), 32'(v.expReq));
    if (v.expReq) check($sformatf("vec%0d imem_addr", idx), imem_addr, v.expAddr);
    check($sformatf("vec%0d instr_valid", idx), 32'(instr_valid), 32'(v.expValid));
    if (v.expValid) begin
      check($sformatf("vec%0d instr", idx), instr, v.expInstr);
      check($sformatf("vec%0d instr_pc", idx), instr_pc, v.expIpc);
    end
  endtask

  task automatic idleInputs();
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
  endtask

  task automatic doReset();
    idleInputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int          transfers;
  logic [31:0] expPc;
  logic        prevPending;
  logic [31:0] prevAddr;
  logic        prevHold;
  logic [31:0] prevInstr;
  logic [31:0] prevIpc;
  logic [31:0] r;

  initial begin
    tests    = 0;
    failures = 0;
    rst_n    = 1'b0;
    idleInputs();

    // Fields: ack rdata redir rpc ready | req addr valid instr instr_pc
    vecs[0]  = mk(0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         32'h0);
    vecs[1]  = mk(1, 32'h2008_0005, 0, 32'h0,         1, 1, 32'h100,       0, 32'h0,         32'h0);
    vecs[2]  = mk(0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         1, 32'h2008_0005, 32'h100);
    vecs[3]  = mk(0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         1, 32'h2008_0005, 32'h100);
    vecs[4]  = mk(0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         1, 32'h2008_0005, 32'h100);
    vecs[5]  = mk(0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         1, 32'h2008_0005, 32'h100);
    vecs[6]  = mk(0, 32'h0,         0, 32'h0,         1, 0, 32'h0,         1, 32'h2008_0005, 32'h100);
    vecs[7]  = mk(0, 32'h0,         1, 32'h0000_0203, 1, 1, 32'h104,       0, 32'h0,         32'h0);
    vecs[8]  = mk(0, 32'h0,         0, 32'h0,         1, 1, 32'h104,       0, 32'h0,         32'h0);
    vecs[9]  = mk(0, 32'h0,         0, 32'h0,         1, 1, 32'h104,       0, 32'h0,         32'h0);
    vecs[10] = mk(1, 32'hDEAD_BEEF, 0, 32'h0,         1, 1, 32'h104,       0, 32'h0,         32'h0);
    vecs[11] = mk(1, 32'hBAD0_BAD0, 1, 32'hFFFF_FFFC, 1, 1, 32'h200,       0, 32'h0,         32'h0);
    vecs[12] = mk(1, 32'h1234_5678, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0);
    vecs[13] = mk(0, 32'h0,         0, 32'h0,         1, 0, 32'h0,         1, 32'h1234_5678, 32'hFFFF_FFFC);
    vecs[14] = mk(0, 32'h0,         0, 32'h0,         1, 1, 32'h0,         0, 32'h0,         32'h0);
    vecs[15] = mk(1, 32'hAAAA_5555, 0, 32'h0,         1, 1, 32'h0,         0, 32'h0,         32'h0);
    vecs[16] = mk(0, 32'h0,         1, 32'h0000_0041, 1, 0, 32'h0,         1, 32'hAAAA_5555, 32'h0);
    vecs[17] = mk(1, 32'h1111_2222, 0, 32'h0,         0, 1, 32'h40,        0, 32'h0,         32'h0);
    vecs[18] = mk(0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         1, 32'h1111_2222, 32'h40);

    doReset();
    check("reset instr", instr, 32'h0);
    check("reset instr_pc", instr_pc, 32'h0);
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i], i);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset while a discarded request is outstanding.
    doReset();
    @(posedge clk);
    #1 imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D; instr_ready = 1'b1;
    @(posedge clk);
    #1 imem_ack = 1'b0;
    @(posedge clk);
    #1 redirect = 1'b1; redirect_pc = 32'h300;
    @(posedge clk);
    #1 redirect = 1'b0;
    @(negedge clk);
    check("discard imem_req", 32'(imem_req), 32'd1);
    check("discard imem_addr", imem_addr, 32'h104);
    check("pre-reset instr", instr, 32'hCAFE_F00D);
    #1 rst_n = 1'b0;
    #1;
    check("async reset imem_req", 32'(imem_req), 32'd0);
    check("async reset instr_valid", 32'(instr_valid), 32'd0);
    check("async reset instr", instr, 32'h0);
    check("async reset instr_pc", instr_pc, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("restart idle imem_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    check("restart imem_req", 32'(imem_req), 32'd1);
    check("restart imem_addr", imem_addr, RESET_PC);

    // Randomized traffic: the model only tracks which address decode should
    // see next; the memory returns a fixed function of the address.
    doReset();
    expPc       = RESET_PC;
    transfers   = 0;
    prevPending = 1'b0;
    prevAddr    = 32'h0;
    prevHold    = 1'b0;
    prevInstr   = 32'h0;
    prevIpc     = 32'h0;
    for (int c = 0; c < 4000; c++) begin
      imem_ack    = imem_req && ($urandom_range(0, 1) == 0);
      imem_rdata  = imem_req ? memWord(imem_addr) : $urandom;
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 11) == 0);
      r = $urandom;
      redirect_pc = (r[0]) ? (32'hFFFF_FFF0 | {28'h0, r[7:4]}) : r;
      @(negedge clk);
      if (imem_req) begin
        check("rand addr aligned", 32'(imem_addr[1:0]), 32'd0);
        if (prevPending) check("rand addr stable", imem_addr, prevAddr);
      end
      if (prevHold) begin
        check("rand valid held", 32'(instr_valid), 32'd1);
        check("rand instr held", instr, prevInstr);
        check("rand instr_pc held", instr_pc, prevIpc);
      end
      if (instr_valid && instr_ready && !redirect) begin
        check("rand instr_pc", instr_pc, expPc);
        check("rand instr", instr, memWord(expPc));
        expPc = expPc + 32'd4;
        transfers++;
      end
      if (redirect) expPc = {redirect_pc[31:2], 2'b00};
      prevPending = imem_req && !imem_ack;
      prevAddr    = imem_addr;
      prevHold    = instr_valid && !instr_ready && !redirect;
      prevInstr   = instr;
      prevIpc     = instr_pc;
      @(posedge clk);
      #1;
    end
    tests++;
    if (transfers < 200) begin
      failures++;
      $display("[TB] FAIL rand progress: got %0d transfers expected at least 200", transfers);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
